// File: rtl/rv32_mod_data_mem_responder.sv
// Data-bus responder: word-organised RAM with byte-enable writes, programmable
// wait states and err for out-of-window or illegal byte-enable accesses.
module rv32_mod_data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic        ack,
  output logic        err,
  output logic [31:0] data_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_mem [0:DEPTH_WORDS-1];

  logic          w_live;
  logic          w_wr;
  logic [3:0]    w_be;
  logic [31:0]   w_addr;
  logic [31:0]   w_data;
  logic          w_fire;
  logic          w_be_ok;
  logic          w_ok;
  logic [AW-1:0] w_idx;

  // With zero wait states the decision is taken on the live request at the
  // capture edge; otherwise it is taken on the captured copy.
  always_comb begin
    w_live  = (r_state == S_IDLE);
    w_wr    = w_live ? wr     : r_wr;
    w_be    = w_live ? be     : r_be;
    w_addr  = w_live ? addr   : r_addr;
    w_data  = w_live ? data_i : r_data;
    w_fire  = w_live ? (req && (WS == 4'd0))
                     : ((r_state == S_WAIT) && req && (r_cnt == 4'd1));
    case (w_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
      default:                   w_be_ok = 1'b0;
    endcase
    w_ok  = w_be_ok && ({1'b0, w_addr} >= LO) && ({1'b0, w_addr} < HI);
    w_idx = w_addr[AW+1:2] - BASE_ADDR[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      data_o  <= '0;
    end else begin
      ack    <= 1'b0;
      err    <= 1'b0;
      data_o <= '0;
      if (w_fire) begin
        r_state <= S_RESP;
        ack     <= w_ok;
        err     <= !w_ok;
        if (w_ok && !w_wr) data_o <= r_mem[w_idx];
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req) begin
              r_wr    <= wr;
              r_be    <= be;
              r_addr  <= addr;
              r_data  <= data_i;
              r_cnt   <= WS;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!req) r_state <= S_IDLE;
            else      r_cnt   <= r_cnt - 4'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_fire && w_ok && w_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule
